// File: rtl/crypto_op_scheduler.sv
// Queues hash/encrypt/decrypt requests from the control decoder and issues them
// one at a time to the shared crypto engine, with completion reporting and a hang watchdog.
module crypto_op_scheduler #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       H_int,
    input  logic                       E_int,
    input  logic                       D_int,
    input  logic [ADDR_W-1:0]          op_addr,
    input  logic                       eng_busy,
    input  logic                       eng_done,
    output logic                       eng_start,
    output logic [1:0]                 eng_op,
    output logic [ADDR_W-1:0]          eng_addr,
    output logic                       cpu_stall,
    output logic                       op_done,
    output logic [1:0]                 op_done_code,
    output logic                       timeout_err,
    output logic [$clog2(DEPTH):0]     pending_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        TOERR = 3'd4
    } state_t;

    state_t              state_reg;
    logic [1:0]          op_mem   [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [TO_W-1:0]     to_cnt_reg;

    logic                eng_start_reg;
    logic [1:0]          eng_op_reg;
    logic [ADDR_W-1:0]   eng_addr_reg;
    logic                op_done_reg;
    logic [1:0]          op_done_code_reg;
    logic                timeout_err_reg;

    logic [1:0]          req_code;
    logic                push;
    logic                pop;

    // Fixed priority H > E > D; lower-priority coincident requests are dropped.
    always_comb begin
        req_code = 2'b00;
        if (H_int)
            req_code = 2'b01;
        else if (E_int)
            req_code = 2'b10;
        else if (D_int)
            req_code = 2'b11;
    end

    assign push = (req_code != 2'b00) && (count_reg < FULL_CNT);
    assign pop  = (state_reg == IDLE) && (count_reg != '0) && !eng_busy;

    // Queue storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_reg]   <= req_code;
            addr_mem[wr_ptr_reg] <= op_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The head entry is popped on the IDLE->ISSUE edge, so it stops counting as pending once in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            to_cnt_reg       <= '0;
            eng_start_reg    <= 1'b0;
            eng_op_reg       <= 2'b00;
            eng_addr_reg     <= '0;
            op_done_reg      <= 1'b0;
            op_done_code_reg <= 2'b00;
            timeout_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    op_done_reg <= 1'b0;
                    if (pop) begin
                        state_reg     <= ISSUE;
                        eng_start_reg <= 1'b1;
                        eng_op_reg    <= op_mem[rd_ptr_reg];
                        eng_addr_reg  <= addr_mem[rd_ptr_reg];
                    end
                end
                ISSUE: begin
                    eng_start_reg <= 1'b0;
                    to_cnt_reg    <= '0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (eng_done) begin
                        state_reg        <= DONE;
                        op_done_reg      <= 1'b1;
                        op_done_code_reg <= eng_op_reg;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg       <= TOERR;
                        timeout_err_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                DONE, TOERR: begin
                    state_reg        <= IDLE;
                    op_done_reg      <= 1'b0;
                    op_done_code_reg <= 2'b00;
                    eng_op_reg       <= 2'b00;
                    eng_addr_reg     <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign eng_start    = eng_start_reg;
    assign eng_op       = eng_op_reg;
    assign eng_addr     = eng_addr_reg;
    assign op_done      = op_done_reg;
    assign op_done_code = op_done_code_reg;
    assign timeout_err  = timeout_err_reg;
    assign pending_cnt  = count_reg;
    assign cpu_stall    = (count_reg == FULL_CNT);

endmodule

// File: tb/tb_crypto_op_scheduler.sv
// Directed bench for crypto_op_scheduler: latency, priority, full-queue stall,
// watchdog timeout, async reset and the done-versus-timeout tie.
module tb_crypto_op_scheduler;

    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              H_int;
    logic              E_int;
    logic              D_int;
    logic [ADDR_W-1:0] op_addr;
    logic              eng_busy;
    logic              eng_done;
    logic              eng_start;
    logic [1:0]        eng_op;
    logic [ADDR_W-1:0] eng_addr;
    logic              cpu_stall;
    logic              op_done;
    logic [1:0]        op_done_code;
    logic              timeout_err;
    logic [2:0]        pending_cnt;

    int checks = 0;
    int errors = 0;

    crypto_op_scheduler #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .H_int        (H_int),
        .E_int        (E_int),
        .D_int        (D_int),
        .op_addr      (op_addr),
        .eng_busy     (eng_busy),
        .eng_done     (eng_done),
        .eng_start    (eng_start),
        .eng_op       (eng_op),
        .eng_addr     (eng_addr),
        .cpu_stall    (cpu_stall),
        .op_done      (op_done),
        .op_done_code (op_done_code),
        .timeout_err  (timeout_err),
        .pending_cnt  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic h, input logic e, input logic d, input logic [ADDR_W-1:0] a);
        H_int   = h;
        E_int   = e;
        D_int   = d;
        op_addr = a;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"},   32'(eng_start),    32'd0);
        chk({tag, "_op"},      32'(eng_op),       32'd0);
        chk({tag, "_addr"},    32'(eng_addr),     32'd0);
        chk({tag, "_stall"},   32'(cpu_stall),    32'd0);
        chk({tag, "_done"},    32'(op_done),      32'd0);
        chk({tag, "_code"},    32'(op_done_code), 32'd0);
        chk({tag, "_to_err"},  32'(timeout_err),  32'd0);
        chk({tag, "_pending"}, 32'(pending_cnt),  32'd0);
    endtask

    logic [1:0]        exp_op   [4];
    logic [ADDR_W-1:0] exp_addr [4];

    initial begin
        rst      = 1'b1;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, '0);
        exp_op   = '{2'b10, 2'b11, 2'b01, 2'b10};
        exp_addr = '{16'd1, 16'd2, 16'd3, 16'd4};

        // Reset state
        step();
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // 1: single hash, start latency 2, done latency 1
        drive_req(1'b1, 1'b0, 1'b0, 16'h0040);       // cycle 0
        step();                                       // cycle 1
        drive_req(1'b0, 1'b0, 1'b0, '0);
        chk("t1_pending_c1", 32'(pending_cnt), 32'd1);
        chk("t1_start_c1",   32'(eng_start),   32'd0);
        step();                                       // cycle 2
        chk("t1_start_c2",   32'(eng_start),   32'd1);
        chk("t1_op_c2",      32'(eng_op),      32'd1);
        chk("t1_addr_c2",    32'(eng_addr),    32'h0040);
        step();                                       // cycle 3
        chk("t1_start_c3",   32'(eng_start),   32'd0);
        chk("t1_op_hold_c3", 32'(eng_op),      32'd1);
        step();                                       // cycle 4
        step();                                       // cycle 5
        chk("t1_done_c5",    32'(op_done),     32'd0);
        eng_done = 1'b1;
        step();                                       // cycle 6
        eng_done = 1'b0;
        chk("t1_done_c6",    32'(op_done),      32'd1);
        chk("t1_code_c6",    32'(op_done_code), 32'd1);
        chk("t1_to_err_c6",  32'(timeout_err),  32'd0);
        step();                                       // cycle 7
        chk("t1_done_c7",    32'(op_done),     32'd0);
        chk("t1_op_idle_c7", 32'(eng_op),      32'd0);
        chk("t1_addr_idle",  32'(eng_addr),    32'd0);

        // 2: H and D together -> only hash queued
        drive_req(1'b1, 1'b0, 1'b1, 16'h0077);
        step();
        drive_req(1'b0, 1'b0, 1'b0, '0);
        chk("t2_pending_c1", 32'(pending_cnt), 32'd1);
        step();
        chk("t2_op_c2",      32'(eng_op),      32'd1);
        chk("t2_pending_c2", 32'(pending_cnt), 32'd0);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t2_code",       32'(op_done_code), 32'd1);
        step();
        step();
        chk("t2_no_second",  32'(eng_start),   32'd0);
        chk("t2_pending_end",32'(pending_cnt), 32'd0);

        // 3: fill queue behind a busy engine, 5th request dropped
        eng_busy = 1'b1;
        drive_req(1'b0, 1'b1, 1'b0, 16'd1);
        step();
        drive_req(1'b0, 1'b0, 1'b1, 16'd2);
        step();
        drive_req(1'b1, 1'b0, 1'b0, 16'd3);
        step();
        chk("t3_stall_at3",  32'(cpu_stall),   32'd0);
        drive_req(1'b0, 1'b1, 1'b0, 16'd4);
        step();
        chk("t3_pending_4",  32'(pending_cnt), 32'd4);
        chk("t3_stall_4",    32'(cpu_stall),   32'd1);
        drive_req(1'b0, 1'b0, 1'b1, 16'd5);
        step();
        drive_req(1'b0, 1'b0, 1'b0, '0);
        chk("t3_pending_5th",32'(pending_cnt), 32'd4);
        chk("t3_start_busy", 32'(eng_start),   32'd0);
        eng_busy = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_start_%0d", i), 32'(eng_start), 32'd1);
            chk($sformatf("t3_op_%0d", i),    32'(eng_op),    32'(exp_op[i]));
            chk($sformatf("t3_addr_%0d", i),  32'(eng_addr),  32'(exp_addr[i]));
            chk($sformatf("t3_pend_%0d", i),  32'(pending_cnt), 32'(3 - i));
            step();
            eng_done = 1'b1;
            step();
            eng_done = 1'b0;
            chk($sformatf("t3_done_%0d", i),  32'(op_done),      32'd1);
            chk($sformatf("t3_code_%0d", i),  32'(op_done_code), 32'(exp_op[i]));
            step();
            step();
        end
        chk("t3_drained",    32'(eng_start),   32'd0);
        chk("t3_pending_end",32'(pending_cnt), 32'd0);
        chk("t3_stall_end",  32'(cpu_stall),   32'd0);

        // 4: encrypt times out after 8 WAIT cycles, queued decrypt still runs
        drive_req(1'b0, 1'b1, 1'b0, 16'h00AA);       // cycle 0
        step();
        drive_req(1'b0, 1'b0, 1'b1, 16'h00BB);       // cycle 1
        step();                                       // cycle 2: ISSUE E
        drive_req(1'b0, 1'b0, 1'b0, '0);
        chk("t4_op_issue",   32'(eng_op),      32'd2);
        for (int i = 0; i < 8; i++) step();           // cycle 10: last WAIT
        chk("t4_to_err_c10", 32'(timeout_err), 32'd0);
        step();                                       // cycle 11: TOERR
        chk("t4_to_err_c11", 32'(timeout_err), 32'd1);
        chk("t4_no_done",    32'(op_done),     32'd0);
        chk("t4_op_hold",    32'(eng_op),      32'd2);
        step();                                       // cycle 12: IDLE
        chk("t4_no_done_c12",32'(op_done),     32'd0);
        step();                                       // cycle 13: ISSUE D
        chk("t4_d_start",    32'(eng_start),   32'd1);
        chk("t4_d_op",       32'(eng_op),      32'd3);
        chk("t4_d_addr",     32'(eng_addr),    32'h00BB);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("t4_d_done",     32'(op_done),      32'd1);
        chk("t4_d_code",     32'(op_done_code), 32'd3);
        chk("t4_sticky",     32'(timeout_err),  32'd1);
        step();

        // 5: async reset mid-WAIT with two ops queued
        drive_req(1'b1, 1'b0, 1'b0, 16'h0010);
        step();
        drive_req(1'b0, 1'b1, 1'b0, 16'h0020);
        step();
        drive_req(1'b0, 1'b0, 1'b1, 16'h0030);
        step();                                       // cycle 3: WAIT
        drive_req(1'b0, 1'b0, 1'b0, '0);
        chk("t5_op_wait",    32'(eng_op),      32'd1);
        chk("t5_pending_2",  32'(pending_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        step();
        step();
        rst = 1'b0;
        eng_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_no_done_%0d", i),  32'(op_done),     32'd0);
            chk($sformatf("t5_no_start_%0d", i), 32'(eng_start),   32'd0);
            chk($sformatf("t5_empty_%0d", i),    32'(pending_cnt), 32'd0);
        end
        eng_done = 1'b0;
        step();

        // 6: done on the same cycle the counter reaches TIMEOUT-1
        drive_req(1'b1, 1'b0, 1'b0, 16'h0099);       // cycle 0
        step();
        drive_req(1'b0, 1'b0, 1'b0, '0);
        step();                                       // cycle 2: ISSUE
        chk("t6_start",      32'(eng_start),   32'd1);
        for (int i = 0; i < 8; i++) step();           // cycle 10: counter at 7
        chk("t6_to_err_pre", 32'(timeout_err), 32'd0);
        eng_done = 1'b1;
        step();                                       // cycle 11
        eng_done = 1'b0;
        chk("t6_done",       32'(op_done),      32'd1);
        chk("t6_code",       32'(op_done_code), 32'd1);
        chk("t6_to_err",     32'(timeout_err),  32'd0);
        step();
        chk("t6_done_end",   32'(op_done),      32'd0);
        chk("t6_to_err_end", 32'(timeout_err),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
